// File: rtl/mux_pkg.sv
// Shared select encoding for the 4-to-1 steering mux.
// Keeps the select type and its named codes in one place for all users.
package mux_pkg;

  typedef logic [1:0] mux_sel_t;

  localparam mux_sel_t SEL_A = 2'b00;
  localparam mux_sel_t SEL_B = 2'b01;
  localparam mux_sel_t SEL_C = 2'b10;
  localparam mux_sel_t SEL_D = 2'b11;

endpackage : mux_pkg

// File: rtl/mux_4x1_core.sv
// Combinational WIDTH-bit 4-to-1 case mux.
// An unknown select drives all-X in simulation and adds no hardware.
module mux_4x1_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  mux_sel_t         sel,
  output logic [WIDTH-1:0] op
);

  always_comb begin
    // NOTE: every path through this block assigns op, so no latch is inferred;
    // the default arm is reached only by an X/Z select and propagates X.
    case (sel)
      SEL_A:   op = a;
      SEL_B:   op = b;
      SEL_C:   op = c;
      SEL_D:   op = d;
      default: op = 'x;
    endcase
  end

endmodule : mux_4x1_core

// File: rtl/mux_4x1.sv
// 4-to-1 selector: zero-latency op plus a registered copy op_q.
// Select is {s1,s2} with s1 as the MSB; op_q clears on a synchronous rst.
module mux_4x1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] op,
  output logic [WIDTH-1:0] op_q
);

  mux_sel_t sel;

  assign sel = {s1, s2};

  mux_4x1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .op  (op)
  );

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignment so every reader of op_q in this edge sees
    // the pre-edge value, independent of process ordering.
    if (rst) op_q <= '0;
    else     op_q <= op;
  end

endmodule : mux_4x1

// File: tb/tb_mux_4x1.sv
// Randomized and directed bench for mux_4x1 with a queue-based scoreboard.
// Stimulus pushes expected values; independent monitors pop and compare.
module tb_mux_4x1;

  localparam int W = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] c   = '0;
  logic [W-1:0] d   = '0;
  logic         s1  = 1'b0;
  logic         s2  = 1'b0;
  logic [W-1:0] op;
  logic [W-1:0] op_q;

  mux_4x1 #(
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .s1   (s1),
    .s2   (s2),
    .op   (op),
    .op_q (op_q)
  );

  always #15 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] exp;
  } exp_t;

  exp_t         comb_q[$];
  logic [W-1:0] reg_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  event         stim_ev;

  // Reference: the inputs form a 4-entry table indexed by the select value.
  function automatic logic [W-1:0] model(input logic [W-1:0] va, vb, vc, vd,
                                         input logic vs1, vs2);
    logic [W-1:0] din[4];
    int           idx;
    din = '{va, vb, vc, vd};
    idx = 2 * int'(vs1) + int'(vs2);
    return din[idx];
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input string nm, input logic r,
                       input logic [W-1:0] va, vb, vc, vd, input logic [1:0] s);
    @(posedge clk);
    #1;
    rst = r;
    a = va; b = vb; c = vc; d = vd;
    {s1, s2} = s;
    comb_q.push_back('{name: nm, exp: model(va, vb, vc, vd, s[1], s[0])});
    -> stim_ev;
  endtask

  // Register model: what op_q must hold after each rising edge.
  always @(posedge clk) reg_q.push_back(rst ? '0 : model(a, b, c, d, s1, s2));

  initial begin : reg_monitor
    forever begin
      @(negedge clk);
      if (reg_q.size() > 0) check("op_q", op_q, reg_q.pop_front());
    end
  end

  initial begin : comb_monitor
    exp_t e;
    forever begin
      @(stim_ev);
      #10;
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check(e.name, op, e.exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin : stimulus
    // T5 part 1: hold reset two cycles while op follows the inputs.
    apply("T5_rst_op", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    apply("T5_rst_op", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    // T5 part 2: release, select d=1; op_q becomes 1 one clock later.
    apply("T5_sel_d", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    apply("T5_hold",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    // T6: one reset edge mid-run, then reload.
    apply("T6_rst",   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    apply("T6_rel",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    apply("T6_hold",  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);

    // T1: select a.
    apply("T1_a1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    apply("T1_a0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

    // T2: b, c, d alone, then all zero at the same selects.
    apply("T2_b1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b01);
    apply("T2_c1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10);
    apply("T2_d1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11);
    apply("T2_b0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
    apply("T2_c0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10);
    apply("T2_d0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11);

    // T3: only the selected input is 0.
    apply("T3_a", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00);
    apply("T3_b", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
    apply("T3_c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
    apply("T3_d", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);

    // T4: exhaustive {a,b,c,d,s1,s2}.
    for (int i = 0; i < 64; i++) begin
      logic [5:0] v;
      v = i[5:0];
      apply("T4_exh", 1'b0, v[5], v[4], v[3], v[2], v[1:0]);
    end

    // Randomized traffic with occasional reset pulses.
    repeat (200) begin
      apply("RAND", ($urandom_range(0, 7) == 0),
            W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            2'($urandom_range(0, 3)));
    end

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", comb_q.size(), reg_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux_4x1
